// File: rtl/stage_ctrl_pkg.sv
// Shared types for the stage sequencer: instruction classes, FSM state
// encoding, the registered strobe bundle and class decode helpers.
package stage_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b0;

  typedef logic [3:0] alu_sel_bus_t;

  localparam alu_sel_bus_t EXE_RES_NOP  = 4'd0;
  localparam alu_sel_bus_t EXE_RES_R    = 4'd1;
  localparam alu_sel_bus_t EXE_RES_I    = 4'd2;
  localparam alu_sel_bus_t EXE_RES_LW   = 4'd3;
  localparam alu_sel_bus_t EXE_RES_SW   = 4'd4;
  localparam alu_sel_bus_t EXE_RES_B    = 4'd5;
  localparam alu_sel_bus_t EXE_RES_NB   = 4'd6;
  localparam alu_sel_bus_t EXE_RES_JAL  = 4'd7;
  localparam alu_sel_bus_t EXE_RES_JALR = 4'd8;

  // One-hot so every strobe decodes from a single flop.
  typedef enum logic [8:0] {
    S_IDLE   = 9'b0_0000_0001,
    S_FETCH  = 9'b0_0000_0010,
    S_LATCH  = 9'b0_0000_0100,
    S_DECODE = 9'b0_0000_1000,
    S_EXEC   = 9'b0_0001_0000,
    S_MEM    = 9'b0_0010_0000,
    S_WB     = 9'b0_0100_0000,
    S_HALT   = 9'b0_1000_0000,
    S_TRAP   = 9'b1_0000_0000
  } state_t;

  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic if_en;
    logic id_en;
    logic ex_en;
    logic wb_en;
    logic pc_upd;
    logic pc_sel;
    logic halted;
    logic illegal;
  } ctrl_t;

  function automatic logic cls_is_mem(alu_sel_bus_t c);
    return (c == EXE_RES_LW) || (c == EXE_RES_SW);
  endfunction

  function automatic logic cls_writes(alu_sel_bus_t c);
    return c inside {EXE_RES_R, EXE_RES_I, EXE_RES_LW, EXE_RES_JAL, EXE_RES_JALR};
  endfunction

  function automatic logic cls_redirects(alu_sel_bus_t c);
    return c inside {EXE_RES_B, EXE_RES_JAL, EXE_RES_JALR};
  endfunction

  function automatic logic cls_legal(alu_sel_bus_t c);
    return (c >= EXE_RES_R) && (c <= EXE_RES_JALR);
  endfunction

endpackage

// File: rtl/stage_ctrl_if.sv
// Control bundle between the stage sequencer (master) and the datapath and
// memories it steps (slave).
interface stage_ctrl_if;
  import stage_ctrl_pkg::*;

  alu_sel_bus_t alusel_i;
  logic         imem_ack_i;
  logic         dmem_ack_i;
  logic         halt_i;
  logic         imem_req_o;
  logic         dmem_req_o;
  logic         dmem_we_o;
  logic         if_en_o;
  logic         id_en_o;
  logic         ex_en_o;
  logic         wb_en_o;
  logic         pc_upd_o;
  logic         pc_sel_o;
  logic         halted_o;
  logic         err_o;
  logic         illegal_o;
  logic [31:0]  instret_o;

  modport master (
    input  alusel_i, imem_ack_i, dmem_ack_i, halt_i,
    output imem_req_o, dmem_req_o, dmem_we_o, if_en_o, id_en_o, ex_en_o,
           wb_en_o, pc_upd_o, pc_sel_o, halted_o, err_o, illegal_o, instret_o
  );

  modport slave (
    output alusel_i, imem_ack_i, dmem_ack_i, halt_i,
    input  imem_req_o, dmem_req_o, dmem_we_o, if_en_o, id_en_o, ex_en_o,
           wb_en_o, pc_upd_o, pc_sel_o, halted_o, err_o, illegal_o, instret_o
  );

endinterface

// File: rtl/stage_ctrl_wait_timer.sv
// Memory wait timer: counts unacknowledged request cycles and flags the
// cycle in which the limit is reached with no ack.
module stage_ctrl_wait_timer
  import stage_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count;
  logic          at_max;

  assign at_max  = (count == CW'(WAIT_MAX));
  assign expired = en && at_max;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stage_ctrl.sv
// Multi-cycle stage sequencer: one-hot FSM issuing single-cycle stage strobes,
// memory handshakes, PC select, halt, wait-timeout trap and instret counting.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  stage_ctrl_if.master bus
);

  state_t       state;
  ctrl_t        ctrl;
  logic         err;
  alu_sel_bus_t cls;
  logic [31:0]  instret;
  logic         in_wait;
  logic         waiting;
  logic         timeout;

  assign in_wait = (state == S_FETCH) || (state == S_MEM);
  assign waiting = ((state == S_FETCH) && !bus.imem_ack_i) ||
                   ((state == S_MEM)   && !bus.dmem_ack_i);

  // Held at zero outside FETCH/MEM, so it starts from zero on every entry.
  stage_ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_wait),
    .en      (waiting),
    .expired (timeout)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state   <= S_IDLE;
      ctrl    <= '0;
      err     <= 1'b0;
      cls     <= EXE_RES_NOP;
      instret <= '0;
    end else begin
      ctrl <= '0;
      case (state)
        S_IDLE: begin
          state         <= S_FETCH;
          ctrl.imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ack_i) begin
            state      <= S_LATCH;
            ctrl.if_en <= 1'b1;
          end else if (timeout) begin
            state <= S_TRAP;
            err   <= 1'b1;
          end else begin
            ctrl.imem_req <= 1'b1;
          end
        end
        S_LATCH: begin
          state      <= S_DECODE;
          ctrl.id_en <= 1'b1;
        end
        S_DECODE: begin
          state      <= S_EXEC;
          ctrl.ex_en <= 1'b1;
        end
        S_EXEC: begin
          cls <= bus.alusel_i;
          if (cls_is_mem(bus.alusel_i)) begin
            state         <= S_MEM;
            ctrl.dmem_req <= 1'b1;
            ctrl.dmem_we  <= (bus.alusel_i == EXE_RES_SW);
          end else begin
            // Illegal classes still retire so the PC moves past them.
            state        <= S_WB;
            ctrl.pc_upd  <= 1'b1;
            ctrl.wb_en   <= cls_writes(bus.alusel_i);
            ctrl.pc_sel  <= cls_redirects(bus.alusel_i);
            ctrl.illegal <= !cls_legal(bus.alusel_i);
          end
        end
        S_MEM: begin
          if (bus.dmem_ack_i) begin
            state       <= S_WB;
            ctrl.pc_upd <= 1'b1;
            ctrl.wb_en  <= cls_writes(cls);
          end else if (timeout) begin
            state <= S_TRAP;
            err   <= 1'b1;
          end else begin
            ctrl.dmem_req <= 1'b1;
            ctrl.dmem_we  <= (cls == EXE_RES_SW);
          end
        end
        S_WB: begin
          instret <= instret + 32'd1;
          if (bus.halt_i) begin
            state       <= S_HALT;
            ctrl.halted <= 1'b1;
          end else begin
            state         <= S_FETCH;
            ctrl.imem_req <= 1'b1;
          end
        end
        S_HALT: begin
          if (!bus.halt_i) begin
            state         <= S_FETCH;
            ctrl.imem_req <= 1'b1;
          end else begin
            ctrl.halted <= 1'b1;
          end
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req_o = ctrl.imem_req;
  assign bus.dmem_req_o = ctrl.dmem_req;
  assign bus.dmem_we_o  = ctrl.dmem_we;
  assign bus.if_en_o    = ctrl.if_en;
  assign bus.id_en_o    = ctrl.id_en;
  assign bus.ex_en_o    = ctrl.ex_en;
  assign bus.wb_en_o    = ctrl.wb_en;
  assign bus.pc_upd_o   = ctrl.pc_upd;
  assign bus.pc_sel_o   = ctrl.pc_sel;
  assign bus.halted_o   = ctrl.halted;
  assign bus.illegal_o  = ctrl.illegal;
  assign bus.err_o      = err;
  assign bus.instret_o  = instret;

endmodule
